// File: rtl/yanoc_pkg.sv
// Shared definitions for the YANOC router input stage.
// Holds the flit-type encodings, packet FSM states, error-bit positions
// and small helpers that compute flit field positions and counter widths.
package yanoc_pkg;

  // Flit-type encodings carried in the top field of every flit
  typedef enum logic [1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_TAIL   = 2'b01,
    FLIT_HEADER = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  // Per-VC packet tracking states
  typedef enum logic {
    PKT_IDLE = 1'b0,
    PKT_BUSY = 1'b1
  } pkt_state_e;

  // Bit positions inside the sticky error vector
  localparam int ERR_OVERFLOW = 0;
  localparam int ERR_BAD_VC   = 1;
  localparam int ERR_PROTOCOL = 2;
  localparam int ERR_WIDTH    = 3;

  // Total flit width: {type, vc_onehot, payload}
  function automatic int flit_width_f(input int pyld_w, input int type_w, input int vc_num);
    return pyld_w + type_w + vc_num;
  endfunction

  // LSB of the one-hot VC field
  function automatic int vc_field_lsb(input int pyld_w);
    return pyld_w;
  endfunction

  // LSB of the flit-type field
  function automatic int type_field_lsb(input int pyld_w, input int vc_num);
    return pyld_w + vc_num;
  endfunction

  // Occupancy counter width able to hold 0..depth inclusive
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/vc_fifo.sv
// Single virtual-channel flit FIFO.
// Ports:
//   clk, reset   - clock and asynchronous active-low reset
//   wr_en        - store wr_data this cycle (caller guarantees room or a same-cycle pop)
//   rd_en        - drop the head entry this cycle (caller guarantees not empty)
//   wr_data      - flit to store
//   rd_data      - current head flit, combinational from storage
//   full, empty  - occupancy status
module vc_fifo
  import yanoc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 14,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Storage is not reset; consumers qualify the head with the empty flag
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Depth is a power of two, so the pointers wrap by natural overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/vc_input_buffer.sv
// Router input port buffer with one FIFO and one packet-tracking FSM per VC.
// Ports:
//   clk, reset      - clock and asynchronous active-low reset
//   flit_in         - incoming flit {type, vc_onehot, payload}
//   wr_in_en        - flit_in valid this cycle
//   rd_vc_en        - one-hot pop request from the switch allocator
//   flit_out_array  - head flit of every VC, VC0 in the LSBs
//   vc_not_empty    - VC holds at least one flit
//   vc_busy         - VC is inside a multi-flit packet
//   credit_out      - registered one-cycle credit pulse per successful pop
//   err_flags       - sticky {protocol, bad VC id, overflow}
module vc_input_buffer
  import yanoc_pkg::*;
#(
  parameter int VC_NUM_PER_PORT   = 2,
  parameter int BUFFER_NUM_PER_VC = 4,
  parameter int PYLD_WIDTH        = 10,
  parameter int FLIT_TYPE_WIDTH   = 2,
  localparam int VC_ID_WIDTH      = VC_NUM_PER_PORT,
  localparam int FLIT_WIDTH       = flit_width_f(PYLD_WIDTH, FLIT_TYPE_WIDTH, VC_ID_WIDTH)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [FLIT_WIDTH-1:0]                 flit_in,
  input  logic                                  wr_in_en,
  input  logic [VC_NUM_PER_PORT-1:0]            rd_vc_en,
  output logic [FLIT_WIDTH*VC_NUM_PER_PORT-1:0] flit_out_array,
  output logic [VC_NUM_PER_PORT-1:0]            vc_not_empty,
  output logic [VC_NUM_PER_PORT-1:0]            vc_busy,
  output logic [VC_NUM_PER_PORT-1:0]            credit_out,
  output logic [ERR_WIDTH-1:0]                  err_flags
);

  localparam logic [VC_ID_WIDTH-1:0] VC_ONE = (VC_ID_WIDTH)'(1);

  logic [VC_ID_WIDTH-1:0]     vc_field;
  logic [1:0]                 type_bits;
  flit_type_e                 flit_type;
  logic                       vc_field_ok;
  logic                       rd_onehot;
  logic [VC_NUM_PER_PORT-1:0] wr_sel;
  logic [VC_NUM_PER_PORT-1:0] wr_accept;
  logic [VC_NUM_PER_PORT-1:0] pop;
  logic [VC_NUM_PER_PORT-1:0] fifo_full;
  logic [VC_NUM_PER_PORT-1:0] fifo_empty;
  logic [VC_NUM_PER_PORT-1:0] proto_err;
  logic [ERR_WIDTH-1:0]       err_set;
  logic [VC_NUM_PER_PORT-1:0] credit_q;
  logic [ERR_WIDTH-1:0]       err_q;

  // The type encoding lives in the low two bits of the type field
  assign vc_field  = flit_in[vc_field_lsb(PYLD_WIDTH) +: VC_ID_WIDTH];
  assign type_bits = flit_in[type_field_lsb(PYLD_WIDTH, VC_ID_WIDTH) +: 2];
  assign flit_type = flit_type_e'(type_bits);

  // x & (x-1) clears the lowest set bit, so zero means at most one bit set
  assign vc_field_ok = (vc_field != '0) && ((vc_field & (vc_field - VC_ONE)) == '0);
  assign rd_onehot   = (rd_vc_en != '0) && ((rd_vc_en & (rd_vc_en - VC_ONE)) == '0);

  assign wr_sel    = (wr_in_en && vc_field_ok) ? vc_field : '0;
  assign pop       = rd_onehot ? (rd_vc_en & ~fifo_empty) : '0;
  // A full VC still takes the write when its head leaves in the same cycle
  assign wr_accept = wr_sel & (~fifo_full | pop);

  assign err_set[ERR_OVERFLOW] = |(wr_sel & fifo_full & ~pop);
  assign err_set[ERR_BAD_VC]   = wr_in_en & ~vc_field_ok;
  assign err_set[ERR_PROTOCOL] = |proto_err;

  for (genvar v = 0; v < VC_NUM_PER_PORT; v++) begin : g_vc
    pkt_state_e state_q;
    pkt_state_e state_d;
    logic       proto_err_d;

    vc_fifo #(
      .DEPTH (BUFFER_NUM_PER_VC),
      .WIDTH (FLIT_WIDTH)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_accept[v]),
      .rd_en   (pop[v]),
      .wr_data (flit_in),
      .rd_data (flit_out_array[v*FLIT_WIDTH +: FLIT_WIDTH]),
      .full    (fifo_full[v]),
      .empty   (fifo_empty[v])
    );

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= PKT_IDLE;
      end else begin
        state_q <= state_d;
      end
    end

    // Out-of-order types are flagged but the flit is kept and the FSM still
    // follows the type, so the VC resynchronises on the next packet
    always_comb begin
      state_d     = state_q;
      proto_err_d = 1'b0;
      if (wr_accept[v]) begin
        case (flit_type)
          FLIT_HEADER: begin
            state_d     = PKT_BUSY;
            proto_err_d = (state_q == PKT_BUSY);
          end
          FLIT_SINGLE: begin
            state_d     = PKT_IDLE;
            proto_err_d = (state_q == PKT_BUSY);
          end
          FLIT_BODY: begin
            state_d     = PKT_BUSY;
            proto_err_d = (state_q == PKT_IDLE);
          end
          FLIT_TAIL: begin
            state_d     = PKT_IDLE;
            proto_err_d = (state_q == PKT_IDLE);
          end
          default: begin
            state_d     = state_q;
            proto_err_d = 1'b0;
          end
        endcase
      end
    end

    assign proto_err[v] = proto_err_d;
    assign vc_busy[v]   = (state_q == PKT_BUSY);
  end

  // Credits follow pops by one cycle; error bits accumulate until reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credit_q <= '0;
      err_q    <= '0;
    end else begin
      credit_q <= pop;
      err_q    <= err_q | err_set;
    end
  end

  assign credit_out   = credit_q;
  assign err_flags    = err_q;
  assign vc_not_empty = ~fifo_empty;

endmodule

// File: tb/tb_vc_input_buffer.sv
module tb_vc_input_buffer;

  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_TAIL   = 2'b01;
  localparam logic [1:0] T_HEADER = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  logic        clk;
  logic        reset;
  logic [13:0] flit_in;
  logic        wr_in_en;
  logic [1:0]  rd_vc_en;
  logic [27:0] flit_out_array;
  logic [1:0]  vc_not_empty;
  logic [1:0]  vc_busy;
  logic [1:0]  credit_out;
  logic [2:0]  err_flags;

  int tests_run;
  int tests_failed;

  logic [9:0] head0;
  logic [9:0] head1;
  assign head0 = flit_out_array[9:0];
  assign head1 = flit_out_array[23:14];

  vc_input_buffer dut (
    .clk            (clk),
    .reset          (reset),
    .flit_in        (flit_in),
    .wr_in_en       (wr_in_en),
    .rd_vc_en       (rd_vc_en),
    .flit_out_array (flit_out_array),
    .vc_not_empty   (vc_not_empty),
    .vc_busy        (vc_busy),
    .credit_out     (credit_out),
    .err_flags      (err_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [13:0] mk(input logic [1:0] t, input logic [1:0] vc, input logic [9:0] p);
    return {t, vc, p};
  endfunction

  // Drive one cycle of inputs, then return to idle 1 time unit after the edge
  task automatic applyStimulus(input logic wr, input logic [13:0] f, input logic [1:0] rd);
    wr_in_en = wr;
    flit_in  = f;
    rd_vc_en = rd;
    @(posedge clk);
    #1;
    wr_in_en = 1'b0;
    rd_vc_en = 2'b00;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic resetPulse();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    applyStimulus(1'b0, 14'h0, 2'b00);
  endtask

  logic [9:0] exp3 [4];

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset    = 1'b0;
    wr_in_en = 1'b0;
    flit_in  = '0;
    rd_vc_en = '0;
    exp3 = '{10'h021, 10'h022, 10'h023, 10'h3FF};

    // Reset state
    #12;
    checkOutput("rst_not_empty", 32'(vc_not_empty), 32'h0);
    checkOutput("rst_busy", 32'(vc_busy), 32'h0);
    checkOutput("rst_credit", 32'(credit_out), 32'h0);
    checkOutput("rst_err", 32'(err_flags), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Packet HEADER/BODY/TAIL on VC0, then three spaced pops
    applyStimulus(1'b1, mk(T_HEADER, 2'b01, 10'h001), 2'b00);
    checkOutput("pkt_busy_hdr", 32'(vc_busy), 32'h1);
    checkOutput("pkt_ne_hdr", 32'(vc_not_empty), 32'h1);
    checkOutput("pkt_head_hdr", 32'(head0), 32'h001);
    applyStimulus(1'b1, mk(T_BODY, 2'b01, 10'h002), 2'b00);
    checkOutput("pkt_busy_body", 32'(vc_busy), 32'h1);
    applyStimulus(1'b1, mk(T_TAIL, 2'b01, 10'h003), 2'b00);
    checkOutput("pkt_busy_tail", 32'(vc_busy), 32'h0);
    checkOutput("pkt_err", 32'(err_flags), 32'h0);
    for (int i = 1; i <= 3; i++) begin
      checkOutput("pkt_pop_head", 32'(head0), 32'(i));
      applyStimulus(1'b0, 14'h0, 2'b01);
      checkOutput("pkt_credit_on", 32'(credit_out), 32'h1);
      applyStimulus(1'b0, 14'h0, 2'b00);
      checkOutput("pkt_credit_off", 32'(credit_out), 32'h0);
    end
    checkOutput("pkt_drained", 32'(vc_not_empty), 32'h0);

    // Overflow: five SINGLE flits into VC1
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, mk(T_SINGLE, 2'b10, 10'(16 + i)), 2'b00);
      checkOutput("ovf_err", 32'(err_flags), (i == 4) ? 32'h1 : 32'h0);
    end
    checkOutput("ovf_ne", 32'(vc_not_empty), 32'h2);
    for (int i = 0; i < 4; i++) begin
      checkOutput("ovf_head", 32'(head1), 32'(16 + i));
      applyStimulus(1'b0, 14'h0, 2'b10);
      checkOutput("ovf_credit", 32'(credit_out), 32'h2);
    end
    checkOutput("ovf_drained", 32'(vc_not_empty), 32'h0);
    applyStimulus(1'b0, 14'h0, 2'b10);
    checkOutput("ovf_fifth_pop_credit", 32'(credit_out), 32'h0);
    checkOutput("ovf_err_sticky", 32'(err_flags), 32'h1);

    resetPulse();
    checkOutput("rst2_err", 32'(err_flags), 32'h0);

    // Full VC1 with simultaneous write and pop
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, mk(T_SINGLE, 2'b10, 10'(32 + i)), 2'b00);
    end
    checkOutput("full_ne", 32'(vc_not_empty), 32'h2);
    applyStimulus(1'b1, mk(T_SINGLE, 2'b10, 10'h3FF), 2'b10);
    checkOutput("full_wrrd_err", 32'(err_flags), 32'h0);
    checkOutput("full_wrrd_credit", 32'(credit_out), 32'h2);
    for (int i = 0; i < 4; i++) begin
      checkOutput("full_head", 32'(head1), 32'(exp3[i]));
      applyStimulus(1'b0, 14'h0, 2'b10);
    end
    checkOutput("full_drained", 32'(vc_not_empty), 32'h0);

    resetPulse();

    // Bad VC ids, then BODY into an idle VC
    applyStimulus(1'b1, mk(T_HEADER, 2'b11, 10'h005), 2'b00);
    checkOutput("badvc_err", 32'(err_flags), 32'h2);
    checkOutput("badvc_ne", 32'(vc_not_empty), 32'h0);
    checkOutput("badvc_busy", 32'(vc_busy), 32'h0);
    applyStimulus(1'b1, mk(T_HEADER, 2'b00, 10'h005), 2'b00);
    checkOutput("zerovc_ne", 32'(vc_not_empty), 32'h0);
    applyStimulus(1'b1, mk(T_BODY, 2'b01, 10'h006), 2'b00);
    checkOutput("proto_err", 32'(err_flags), 32'h6);
    checkOutput("proto_ne", 32'(vc_not_empty), 32'h1);
    checkOutput("proto_head", 32'(head0), 32'h006);
    checkOutput("proto_busy", 32'(vc_busy), 32'h1);

    // Pop of an empty VC and a non-one-hot pop request
    applyStimulus(1'b0, 14'h0, 2'b10);
    checkOutput("emptypop_credit", 32'(credit_out), 32'h0);
    checkOutput("emptypop_ne", 32'(vc_not_empty), 32'h1);
    applyStimulus(1'b0, 14'h0, 2'b11);
    checkOutput("dualpop_credit", 32'(credit_out), 32'h0);
    checkOutput("dualpop_ne", 32'(vc_not_empty), 32'h1);
    checkOutput("dualpop_head", 32'(head0), 32'h006);
    applyStimulus(1'b0, 14'h0, 2'b00);
    checkOutput("dualpop_credit_after", 32'(credit_out), 32'h0);

    resetPulse();

    // Reset mid-packet with a pop pending
    applyStimulus(1'b1, mk(T_HEADER, 2'b01, 10'h007), 2'b00);
    applyStimulus(1'b1, mk(T_BODY, 2'b01, 10'h008), 2'b00);
    applyStimulus(1'b1, mk(T_HEADER, 2'b11, 10'h000), 2'b00);
    checkOutput("mid_busy", 32'(vc_busy), 32'h1);
    checkOutput("mid_head", 32'(head0), 32'h007);
    checkOutput("mid_err", 32'(err_flags), 32'h2);
    rd_vc_en = 2'b01;
    #2;
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_ne", 32'(vc_not_empty), 32'h0);
    checkOutput("mid_rst_busy", 32'(vc_busy), 32'h0);
    checkOutput("mid_rst_err", 32'(err_flags), 32'h0);
    checkOutput("mid_rst_credit", 32'(credit_out), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("mid_rst_credit_edge", 32'(credit_out), 32'h0);
    reset    = 1'b1;
    rd_vc_en = 2'b00;
    applyStimulus(1'b0, 14'h0, 2'b00);
    checkOutput("post_rst_credit", 32'(credit_out), 32'h0);
    checkOutput("post_rst_ne", 32'(vc_not_empty), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
